dcm_lock_ctrl: RTL and testbench
================================

# dcm_lock_ctrl

Reset/lock sequencer for the Spartan-6 DCM_SP clock wrapper on the AD front end. Runs on an independent free-running clock, drives the DCM reset with a guaranteed minimum pulse, and qualifies LOCKED with a stability window before declaring the synthesized clock usable. It also detects lock loss and stopped-clock status, retries up to a limit, and then latches a failure flag for the system controller.

## Interface
- RST_HOLD_CYC, 8: cycles `dcm_reset` is held high per reset attempt (DCM_SP needs ≥3 CLKIN periods; 8 gives margin). Minimum 1.
- LOCK_TIMEOUT, 65535: maximum cycles in WAIT_LOCK before the attempt counts as failed.
- LOCK_STABLE_CYC, 256: consecutive synchronized-locked cycles required before `dcm_ready`.
- MAX_RETRY, 7: failed attempts allowed before FAIL. 0 means FAIL on the first failure.
- clk  in  1  free-running controller clock, independent of the DCM outputs.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  sequencing request. Low forces IDLE.
- locked_in  in  1  DCM LOCKED, asynchronous to `clk`.
- status_in  in  2  DCM STATUS[2:1]. Bit0 = CLKIN stopped, bit1 = CLKFX stopped. Asynchronous.
- dcm_reset  out  1  DCM RST, registered.
- dcm_ready  out  1  DCM clocks qualified, registered.
- fail  out  1  retry budget exhausted, registered.
- retry_cnt  out  4  failed attempts since the last IDLE exit, saturating at 15.

## Operation
- Synchronization:
  - `locked_in` and `status_in` each pass through a 2-flop synchronizer. All decisions use the synchronized copies (`lk_s`, `st_s`).
  - `bad` = `st_s[0] | st_s[1]`.
- States: IDLE, RST, WAIT_LOCK, STABLE, READY, FAIL.
- IDLE:
  - Outputs: `dcm_reset`=1, `dcm_ready`=0, `fail`=0, `retry_cnt`=0.
  - `enable`=1 → RST, timer cleared.
- RST:
  - `dcm_reset`=1 for exactly RST_HOLD_CYC cycles, then → WAIT_LOCK with the timer cleared.
- WAIT_LOCK:
  - `dcm_reset`=0. Timer increments every cycle.
  - `lk_s`=1 and `bad`=0 → STABLE, stable counter cleared.
  - Otherwise, when the timer reaches LOCK_TIMEOUT-1 → retry path.
- STABLE:
  - `dcm_reset`=0. Stable counter increments while `lk_s`=1 and `bad`=0.
  - Reaching LOCK_STABLE_CYC-1 → READY.
  - Any cycle with `lk_s`=0 or `bad`=1 → retry path. There is no fallback to WAIT_LOCK.
- READY:
  - `dcm_ready`=1.
  - `lk_s`=0 or `bad`=1 → retry path. `dcm_ready` drops on the same edge the state leaves READY.
- Retry path (a transition, not a state):
  - `retry_cnt` < MAX_RETRY → `retry_cnt`+1, go to RST.
  - Otherwise → FAIL with `retry_cnt`+1.
- FAIL:
  - `dcm_reset`=1, `fail`=1, `dcm_ready`=0. Held until `enable`=0.
- `enable`=0 in any state → IDLE on the next edge. This has priority over every other transition.
- Counters:
  - The timer is wide enough for LOCK_TIMEOUT and the stable counter wide enough for LOCK_STABLE_CYC.
  - Neither counter wraps: each is cleared on state entry.
- Reset mid-operation (`reset_n` low):
  - Asynchronously forces IDLE, `dcm_reset`=1, `dcm_ready`=0, `fail`=0, `retry_cnt`=0, all counters and synchronizers 0.

## Timing
- All outputs are registered. Reset values: `dcm_reset`=1, `dcm_ready`=0, `fail`=0, `retry_cnt`=0.
- Entry into RST:
  - From IDLE, `enable` sampled high at edge N → first RST cycle begins at N. `dcm_reset` stays 1 continuously from IDLE through RST.
  - From a retry, `dcm_reset` rises 1 cycle after the retry decision. `dcm_ready` falls at the same edge.
- `dcm_reset` falls at the edge ending the RST_HOLD_CYC-th RST cycle.
- Input latency: a `locked_in` or `status_in` change takes 2 cycles to reach `lk_s` or `st_s`, and 1 more cycle to move the state.
- Best-case `dcm_ready` rise after entering WAIT_LOCK with LOCKED already high: 2 (sync) + 1 (→STABLE) + LOCK_STABLE_CYC cycles.
- Lock loss in READY: `dcm_ready` deasserts 3 cycles after `locked_in` falls, and `dcm_reset` asserts on the same edge.
- Simultaneous events:
  - Timeout and lock in the same WAIT_LOCK cycle → lock wins (→ STABLE).
  - `enable`=0 together with a retry → IDLE; `retry_cnt` clears.

## Test plan
Bench parameters: RST_HOLD_CYC=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYC=8, MAX_RETRY=2.

1. Reset release, `enable`=1, `locked_in` rises 10 cycles after `dcm_reset` falls → `dcm_reset` high exactly 4 cycles after leaving IDLE; `dcm_ready`=1 exactly 11 cycles after the `locked_in` rise; `retry_cnt`=0.
2. `locked_in` held 0 → three timeouts of 32 WAIT_LOCK cycles each, each preceded by a 4-cycle reset pulse; `retry_cnt` 1, 2, then 3 with `fail`=1 and `dcm_reset`=1 held. Drop `enable` → IDLE, `retry_cnt`=0, `fail`=0.
3. Locked glitch low for 1 cycle during STABLE (cycle 5 of 8) → retry: `retry_cnt`=1, new 4-cycle reset pulse, `dcm_ready` never asserted.
4. In READY, `status_in`=2'b10 for 1 cycle → `dcm_ready` falls and `dcm_reset` rises 3 cycles later; relock reaches READY with `retry_cnt`=1.
5. `reset_n` pulsed low during WAIT_LOCK and during READY → outputs immediately (asynchronously) at reset values; after release with `enable`=1 a full sequence restarts from RST.
6. `locked_in` rising in the same cycle the timer expires → STABLE entered, `retry_cnt` unchanged.

Source files
------------

// File: rtl/dcm_lock_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// dcm_lock_ctrl - DCM_SP reset pulse, LOCKED qualification, retry/fail latch
// Rev 1.0
// ------------------------------------------------------------------------
module dcm_lock_ctrl #(
  parameter int RST_HOLD_CYC    = 8,
  parameter int LOCK_TIMEOUT    = 65535,
  parameter int LOCK_STABLE_CYC = 256,
  parameter int MAX_RETRY       = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       locked_in,
  input  logic [1:0] status_in,
  output logic       dcm_reset,
  output logic       dcm_ready,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  localparam int TMR_MAX = (LOCK_TIMEOUT > RST_HOLD_CYC) ? LOCK_TIMEOUT : RST_HOLD_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int STB_W   = $clog2(LOCK_STABLE_CYC + 1);

  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_WAIT   = 3'd2,
    S_STABLE = 3'd3,
    S_READY  = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [STB_W-1:0] stb_cnt, stb_nxt;
  logic [3:0]       retry_nxt;
  logic [1:0]       lk_sync;
  logic [1:0]       st_meta, st_s;
  logic             lk_s, bad, good, retry;

  assign lk_s = lk_sync[1];
  assign bad  = st_s[0] | st_s[1];
  assign good = lk_s & ~bad;

  // LOCKED and STATUS come from the DCM clock domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lk_sync <= 2'b00;
      st_meta <= 2'b00;
      st_s    <= 2'b00;
    end else begin
      lk_sync <= {lk_sync[0], locked_in};
      st_meta <= status_in;
      st_s    <= st_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    retry     = 1'b0;
    retry_nxt = retry_cnt;
    case (state)
      S_IDLE:   state_nxt = S_RST;
      S_RST:    if (timer == RST_LAST) state_nxt = S_WAIT;
      S_WAIT: begin
        if (good)                    state_nxt = S_STABLE;
        else if (timer == WAIT_LAST) retry     = 1'b1;
      end
      S_STABLE: begin
        if (!good)                   retry     = 1'b1;
        else if (stb_cnt == STB_LAST) state_nxt = S_READY;
      end
      S_READY:  if (!good) retry = 1'b1;
      S_FAIL:   state_nxt = S_FAIL;
      default:  state_nxt = S_IDLE;
    endcase

    if (retry) begin
      retry_nxt = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
      state_nxt = (int'(retry_cnt) < MAX_RETRY) ? S_RST : S_FAIL;
    end

    if (!enable) state_nxt = S_IDLE;
    if (state_nxt == S_IDLE) retry_nxt = 4'd0;

    // Counters restart on every state entry and only advance where they are used
    timer_nxt = '0;
    stb_nxt   = '0;
    if (state_nxt == state) begin
      if (state == S_RST || state == S_WAIT) timer_nxt = timer + TMR_W'(1);
      if (state == S_STABLE)                 stb_nxt   = stb_cnt + STB_W'(1);
    end
  end

  // Outputs are decoded from the next state so they move on the transition edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      stb_cnt   <= '0;
      retry_cnt <= 4'd0;
      dcm_reset <= 1'b1;
      dcm_ready <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      stb_cnt   <= stb_nxt;
      retry_cnt <= retry_nxt;
      dcm_reset <= (state_nxt == S_IDLE) || (state_nxt == S_RST) || (state_nxt == S_FAIL);
      dcm_ready <= (state_nxt == S_READY);
      fail      <= (state_nxt == S_FAIL);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcm_lock_ctrl.sv
`default_nettype none
// tb_dcm_lock_ctrl - directed scenarios plus random stimulus against a
// cycle-level behavioural model of the lock sequencer.
module tb_dcm_lock_ctrl;

  localparam int RST_HOLD = 4;
  localparam int TMO      = 32;
  localparam int STB      = 8;
  localparam int MAXR     = 2;

  localparam int P_IDLE   = 0;
  localparam int P_RST    = 1;
  localparam int P_WAIT   = 2;
  localparam int P_STABLE = 3;
  localparam int P_READY  = 4;
  localparam int P_FAIL   = 5;

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b1;
  logic       enable    = 1'b0;
  logic       locked_in = 1'b0;
  logic [1:0] status_in = 2'b00;
  logic       dcm_reset, dcm_ready, fail;
  logic [3:0] retry_cnt;

  int checks = 0;
  int errors = 0;
  bit ready_seen = 1'b0;

  dcm_lock_ctrl #(
    .RST_HOLD_CYC   (RST_HOLD),
    .LOCK_TIMEOUT   (TMO),
    .LOCK_STABLE_CYC(STB),
    .MAX_RETRY      (MAXR)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .locked_in(locked_in),
    .status_in(status_in),
    .dcm_reset(dcm_reset),
    .dcm_ready(dcm_ready),
    .fail     (fail),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus cycles spent in it, inputs delayed two cycles
  int       m_ph    = P_IDLE;
  int       m_age   = 0;
  int       m_retry = 0;
  bit       m_lk0   = 1'b0;
  bit       m_lk1   = 1'b0;
  bit [1:0] m_st0   = 2'b00;
  bit [1:0] m_st1   = 2'b00;

  always @(posedge clk or negedge reset_n) begin : model
    int nph;
    int nretry;
    bit ok;
    bit lost;
    if (!reset_n) begin
      m_ph    <= P_IDLE;
      m_age   <= 0;
      m_retry <= 0;
      m_lk0   <= 1'b0;
      m_lk1   <= 1'b0;
      m_st0   <= 2'b00;
      m_st1   <= 2'b00;
    end else begin
      ok     = m_lk1 && (m_st1 == 2'b00);
      nph    = m_ph;
      nretry = m_retry;
      lost   = 1'b0;
      case (m_ph)
        P_IDLE:   nph = P_RST;
        P_RST:    if (m_age + 1 >= RST_HOLD) nph = P_WAIT;
        P_WAIT:   if (ok) nph = P_STABLE; else if (m_age + 1 >= TMO) lost = 1'b1;
        P_STABLE: if (!ok) lost = 1'b1; else if (m_age + 1 >= STB) nph = P_READY;
        P_READY:  if (!ok) lost = 1'b1;
        default:  nph = m_ph;
      endcase
      if (lost) begin
        nph    = (m_retry < MAXR) ? P_RST : P_FAIL;
        nretry = (m_retry < 15) ? m_retry + 1 : 15;
      end
      if (!enable) nph = P_IDLE;
      if (nph == P_IDLE) nretry = 0;
      m_age   <= (nph == m_ph) ? m_age + 1 : 0;
      m_ph    <= nph;
      m_retry <= nretry;
      m_lk0   <= locked_in;
      m_lk1   <= m_lk0;
      m_st0   <= status_in;
      m_st1   <= m_st0;
    end
  end

  always @(negedge clk) begin
    chk("model_dcm_reset", dcm_reset, int'(m_ph == P_IDLE || m_ph == P_RST || m_ph == P_FAIL));
    chk("model_dcm_ready", dcm_ready, int'(m_ph == P_READY));
    chk("model_fail",      fail,      int'(m_ph == P_FAIL));
    chk("model_retry_cnt", retry_cnt, m_retry);
  end

  task automatic tick();
    @(posedge clk);
    #2;
    ready_seen = ready_seen | dcm_ready;
  endtask

  function automatic logic sig(input int sel);
    return (sel == 0) ? dcm_reset : dcm_ready;
  endfunction

  // Ticks until the selected output (0: dcm_reset, 1: dcm_ready) equals val
  task automatic ticks_until(input int sel, input logic val, input int bound, output int n);
    n = 0;
    while (sig(sel) != val && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dcm_reset"}, dcm_reset, 1);
    chk({tag, "_dcm_ready"}, dcm_ready, 0);
    chk({tag, "_fail"},      fail,      0);
    chk({tag, "_retry_cnt"}, retry_cnt, 0);
  endtask

  initial begin
    int n;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    chk_reset_vals("por");

    // 1: nominal lock
    reset_n = 1'b1;
    enable  = 1'b1;
    ticks_until(0, 1'b0, 50, n);
    chk("t1_rst_pulse", n, 5);
    repeat (10) tick();
    locked_in = 1'b1;
    ticks_until(1, 1'b1, 100, n);
    chk("t1_ready_latency", n, 11);
    chk("t1_retry_cnt", retry_cnt, 0);
    chk("t1_dcm_reset", dcm_reset, 0);

    // 4: one-cycle CLKFX-stopped status in READY
    status_in = 2'b10;
    tick();
    status_in = 2'b00;
    ticks_until(1, 1'b0, 20, n);
    chk("t4_ready_fall", n + 1, 3);
    chk("t4_reset_rise", dcm_reset, 1);
    chk("t4_retry_cnt", retry_cnt, 1);
    ticks_until(1, 1'b1, 100, n);
    chk("t4_relock", n, 13);
    chk("t4_retry_ready", retry_cnt, 1);

    // 3: LOCKED glitch during the fifth STABLE cycle
    enable = 1'b0;
    tick();
    chk("t3_idle_retry", retry_cnt, 0);
    ready_seen = 1'b0;
    enable = 1'b1;
    repeat (8) tick();
    locked_in = 1'b0;
    tick();
    locked_in = 1'b1;
    ticks_until(0, 1'b1, 20, n);
    chk("t3_react", n, 2);
    ticks_until(0, 1'b0, 20, n);
    chk("t3_pulse", n, 4);
    chk("t3_retry_cnt", retry_cnt, 1);
    chk("t3_no_ready", ready_seen, 0);

    // 2: timeouts until FAIL
    enable    = 1'b0;
    locked_in = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    ticks_until(0, 1'b0, 50, n);
    chk("t2_first_pulse", n, 5);
    for (int a = 1; a <= 3; a++) begin
      ticks_until(0, 1'b1, 100, n);
      chk("t2_wait_len", n, 32);
      chk("t2_retry_cnt", retry_cnt, a);
      if (a < 3) begin
        ticks_until(0, 1'b0, 50, n);
        chk("t2_pulse", n, 4);
      end
    end
    chk("t2_fail", fail, 1);
    repeat (10) tick();
    chk("t2_fail_hold", fail, 1);
    chk("t2_reset_hold", dcm_reset, 1);
    chk("t2_retry_hold", retry_cnt, 3);
    enable = 1'b0;
    tick();
    chk_reset_vals("t2_idle");

    // 6: lock arriving in the timeout cycle wins; one cycle later loses
    enable = 1'b1;
    ticks_until(0, 1'b0, 50, n);
    chk("t6_pulse", n, 5);
    repeat (29) tick();
    locked_in = 1'b1;
    repeat (3) tick();
    chk("t6_reset_low", dcm_reset, 0);
    chk("t6_retry_cnt", retry_cnt, 0);
    ticks_until(1, 1'b1, 50, n);
    chk("t6_ready", n, 8);
    enable    = 1'b0;
    locked_in = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    ticks_until(0, 1'b0, 50, n);
    repeat (30) tick();
    locked_in = 1'b1;
    repeat (3) tick();
    chk("t6_late_reset", dcm_reset, 1);
    chk("t6_late_retry", retry_cnt, 1);
    ticks_until(1, 1'b1, 100, n);
    chk("t6_late_relock", n, 12);

    // 5: asynchronous reset in READY and in WAIT_LOCK
    reset_n = 1'b0;
    #1;
    chk_reset_vals("t5_ready_async");
    repeat (2) tick();
    reset_n = 1'b1;
    ticks_until(0, 1'b0, 50, n);
    chk("t5_restart_pulse", n, 5);
    ticks_until(1, 1'b1, 50, n);
    chk("t5_restart_ready", n, 9);
    locked_in = 1'b0;
    ticks_until(1, 1'b0, 20, n);
    chk("t5_lockloss", n, 3);
    chk("t5_lockloss_reset", dcm_reset, 1);
    ticks_until(0, 1'b0, 20, n);
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk_reset_vals("t5_wait_async");
    tick();
    locked_in = 1'b1;
    reset_n   = 1'b1;
    ticks_until(0, 1'b0, 50, n);
    chk("t5_wait_restart", n, 5);

    // Random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(0, 29) == 0) locked_in = ~locked_in;
      if ($urandom_range(0, 149) == 0) status_in = 2'($urandom_range(1, 3));
      else if (status_in != 2'b00 && $urandom_range(0, 2) == 0) status_in = 2'b00;
      if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 4) == 0) enable = 1'b1;
      if ($urandom_range(0, 799) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
